// File: rtl/pcie_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the PCIe core's AXI4-Stream TX port between N_REQ TLP sources.
// Optional statistics counters are compiled in with `define PCIE_TX_ARB_STATS_EN.
module pcie_tx_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 4,
  parameter int MIN_BUF_AV = 2
) (
  input  logic                          pcie_clk,
  input  logic                          pcie_rst_n,
  input  logic [5:0]                    tx_buf_av,
  input  logic [N_REQ-1:0]              s_axis_tvalid,
  output logic [N_REQ-1:0]              s_axis_tready,
  input  logic [N_REQ*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N_REQ*DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [N_REQ-1:0]              s_axis_tlast,
  input  logic [N_REQ*USER_WIDTH-1:0]   s_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [1:0]                    grant_idx,
`ifdef PCIE_TX_ARB_STATS_EN
  input  logic                          stats_clr,
  output logic [N_REQ*32-1:0]           stats_pkt_cnt,
  output logic [31:0]                   stats_stall_cnt,
`endif
  output logic                          busy
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {IDLE, XFER} state_t;

  state_t     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] grant_idx_q, grant_idx_d;

  logic                  buf_ok;
  logic                  in_xfer;
  logic                  beat_fire;
  logic [3:0]            vld_ext;
  logic                  found;
  logic [1:0]            winner;
  logic [2:0]            cand;
  logic                  sel_tvalid;
  logic                  sel_tlast;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic [KEEP_WIDTH-1:0] sel_tkeep;
  logic [USER_WIDTH-1:0] sel_tuser;

  assign buf_ok  = (tx_buf_av >= 6'(MIN_BUF_AV));
  assign in_xfer = (state_q == XFER);

  // Round-robin search starting at rr_ptr; valids padded to 4 so a 2-bit index is always in range.
  always_comb begin
    vld_ext                = '0;
    vld_ext[N_REQ-1:0]     = s_axis_tvalid;
    found                  = 1'b0;
    winner                 = '0;
    cand                   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + 3'(i);
      if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
      if (!found && vld_ext[cand[1:0]]) begin
        found  = 1'b1;
        winner = cand[1:0];
      end
    end
  end

  always_comb begin
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tuser  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx_q == 2'(i)) begin
        sel_tvalid = s_axis_tvalid[i];
        sel_tlast  = s_axis_tlast[i];
        sel_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tkeep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_tuser  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  always_comb begin
    m_axis_tvalid = in_xfer & sel_tvalid;
    m_axis_tlast  = in_xfer & sel_tlast;
    m_axis_tdata  = in_xfer ? sel_tdata : '0;
    m_axis_tkeep  = in_xfer ? sel_tkeep : '0;
    m_axis_tuser  = in_xfer ? sel_tuser : '0;
    s_axis_tready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      s_axis_tready[i] = in_xfer && (grant_idx_q == 2'(i)) && m_axis_tready;
    end
  end

  assign beat_fire = m_axis_tvalid & m_axis_tready;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    case (state_q)
      IDLE: begin
        if (buf_ok && found) begin
          state_d     = XFER;
          grant_idx_d = winner;
        end
      end
      XFER: begin
        if (beat_fire && sel_tlast) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_idx_q == 2'(N_REQ - 1)) ? 2'd0 : grant_idx_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign grant_idx = grant_idx_q;
  assign busy      = in_xfer;

`ifdef PCIE_TX_ARB_STATS_EN
  logic [31:0] pkt_cnt_q [N_REQ];
  logic [31:0] pkt_cnt_d [N_REQ];
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Clear wins over a same-cycle increment; counters wrap naturally at 2^32.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pkt_cnt_d[i] = pkt_cnt_q[i];
      if (stats_clr) pkt_cnt_d[i] = '0;
      else if (beat_fire && sel_tlast && (grant_idx_q == 2'(i))) pkt_cnt_d[i] = pkt_cnt_q[i] + 32'd1;
    end
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) stall_cnt_d = '0;
    else if (!in_xfer && (|s_axis_tvalid) && !buf_ok) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      for (int unsigned i = 0; i < N_REQ; i++) pkt_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) stats_pkt_cnt[i*32 +: 32] = pkt_cnt_q[i];
  end
  assign stats_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed self-checking bench for pcie_tx_arbiter: a 2-requester instance plus a 3-requester instance for wrap.
module tb_pcie_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   tx_buf_av;

  logic [1:0]   s_tvalid, s_tready, s_tlast;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic [7:0]   s_tuser;
  logic         m_tvalid, m_tready, m_tlast;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic [3:0]   m_tuser;
  logic [1:0]   grant;
  logic         busy;

  logic [2:0]   v3, r3, l3;
  logic [191:0] d3;
  logic [23:0]  k3;
  logic [11:0]  u3;
  logic         mv3, mr3, ml3, b3;
  logic [63:0]  md3;
  logic [7:0]   mk3;
  logic [3:0]   mu3;
  logic [1:0]   g3;

`ifdef PCIE_TX_ARB_STATS_EN
  logic         stats_clr;
  logic [63:0]  pkt_cnt;
  logic [31:0]  stall_cnt;
  logic [95:0]  pkt_cnt3;
  logic [31:0]  stall_cnt3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pcie_tx_arbiter #(.N_REQ(2), .DATA_WIDTH(64), .USER_WIDTH(4), .MIN_BUF_AV(2)) dut (
    .pcie_clk(clk), .pcie_rst_n(rst_n), .tx_buf_av(tx_buf_av),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .grant_idx(grant),
`ifdef PCIE_TX_ARB_STATS_EN
    .stats_clr(stats_clr), .stats_pkt_cnt(pkt_cnt), .stats_stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  pcie_tx_arbiter #(.N_REQ(3), .DATA_WIDTH(64), .USER_WIDTH(4), .MIN_BUF_AV(2)) dut3 (
    .pcie_clk(clk), .pcie_rst_n(rst_n), .tx_buf_av(tx_buf_av),
    .s_axis_tvalid(v3), .s_axis_tready(r3), .s_axis_tdata(d3),
    .s_axis_tkeep(k3), .s_axis_tlast(l3), .s_axis_tuser(u3),
    .m_axis_tvalid(mv3), .m_axis_tready(mr3), .m_axis_tdata(md3),
    .m_axis_tkeep(mk3), .m_axis_tlast(ml3), .m_axis_tuser(mu3),
    .grant_idx(g3),
`ifdef PCIE_TX_ARB_STATS_EN
    .stats_clr(stats_clr), .stats_pkt_cnt(pkt_cnt3), .stats_stall_cnt(stall_cnt3),
`endif
    .busy(b3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [63:0] d);
    s_tvalid[i]          = v;
    s_tlast[i]           = l;
    s_tdata[i*64 +: 64]  = d;
    s_tkeep[i*8 +: 8]    = 8'hFF;
    s_tuser[i*4 +: 4]    = 4'(i + 5);
  endtask

  task automatic set_req3(input int i, input logic v, input logic l, input logic [63:0] d);
    v3[i]            = v;
    l3[i]            = l;
    d3[i*64 +: 64]   = d;
    k3[i*8 +: 8]     = 8'hFF;
    u3[i*4 +: 4]     = 4'(i + 5);
  endtask

  task automatic clear_inputs;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
    v3 = '0; l3 = '0; d3 = '0; k3 = '0; u3 = '0;
    m_tready = 1'b0; mr3 = 1'b0; tx_buf_av = '0;
`ifdef PCIE_TX_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (s_tready !== 2'b00) begin errors++; $display("FAIL reset_s_tready got=%b exp=00", s_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant); end
    checks++; if (m_tdata !== 64'd0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    do_reset();
    tx_buf_av = 6'd8;
    m_tready  = 1'b1;
    set_req(0, 1'b1, 1'b0, 64'h1111_1111_1111_1111);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_idle_tvalid got=%b exp=0", m_tvalid); end
    tick();
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL single_b0_tvalid got=%b exp=1", m_tvalid); end
    checks++; if (m_tdata !== 64'h1111_1111_1111_1111) begin errors++; $display("FAIL single_b0_data got=%h exp=1111111111111111", m_tdata); end
    checks++; if (grant !== 2'd0) begin errors++; $display("FAIL single_grant got=%0d exp=0", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (s_tready !== 2'b01) begin errors++; $display("FAIL single_s_tready got=%b exp=01", s_tready); end
    tick();
    set_req(0, 1'b1, 1'b0, 64'h2222_2222_2222_2222);
    #1;
    checks++; if (m_tdata !== 64'h2222_2222_2222_2222 || m_tlast !== 1'b0) begin errors++; $display("FAIL single_b1 got=%h/%b exp=2222222222222222/0", m_tdata, m_tlast); end
    tick();
    set_req(0, 1'b1, 1'b1, 64'h3333_3333_3333_3333);
    s_tkeep[7:0] = 8'h0F;
    #1;
    checks++; if (m_tdata !== 64'h3333_3333_3333_3333 || m_tlast !== 1'b1) begin errors++; $display("FAIL single_b2 got=%h/%b exp=3333333333333333/1", m_tdata, m_tlast); end
    checks++; if (m_tkeep !== 8'h0F || m_tuser !== 4'h5) begin errors++; $display("FAIL single_keep_user got=%h/%h exp=0f/5", m_tkeep, m_tuser); end
    tick();
    set_req(0, 1'b0, 1'b0, 64'd0);
    #1;
    checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL single_done got busy=%b tvalid=%b exp=0/0", busy, m_tvalid); end
    checks++; if (grant !== 2'd0) begin errors++; $display("FAIL single_grant_hold got=%0d exp=0", grant); end
  endtask

  task automatic test_fairness;
    int bt [2];
    int g;
    do_reset();
    tx_buf_av = 6'd8;
    m_tready  = 1'b1;
    bt[0] = 0; bt[1] = 0;
    for (int p = 0; p < 4; p++) begin
      g = p % 2;
      for (int i = 0; i < 2; i++) set_req(i, 1'b1, bt[i] == 1, {8'(i + 1), 48'd0, 8'(bt[i])});
      #1;
      checks++; if (m_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fair_bubble p=%0d got tvalid=%b busy=%b exp=0/0", p, m_tvalid, busy); end
      tick();
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 2; i++) set_req(i, 1'b1, bt[i] == 1, {8'(i + 1), 48'd0, 8'(bt[i])});
        #1;
        checks++; if (grant !== 2'(g)) begin errors++; $display("FAIL fair_grant p=%0d got=%0d exp=%0d", p, grant, g); end
        checks++; if (m_tdata !== {8'(g + 1), 48'd0, 8'(b)} || m_tlast !== (b == 1)) begin
          errors++; $display("FAIL fair_beat p=%0d b=%0d got=%h/%b exp=%h/%b", p, b, m_tdata, m_tlast, {8'(g + 1), 48'd0, 8'(b)}, (b == 1));
        end
        checks++; if (s_tready !== (2'b01 << g)) begin errors++; $display("FAIL fair_s_tready p=%0d got=%b exp=%b", p, s_tready, 2'b01 << g); end
        tick();
        bt[g] = (b == 1) ? 0 : b + 1;
      end
    end
    s_tvalid = '0;
    tick();
  endtask

  task automatic test_buf_gating;
    do_reset();
    tx_buf_av = 6'd1;
    m_tready  = 1'b1;
`ifdef PCIE_TX_ARB_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
`endif
    set_req(1, 1'b1, 1'b1, 64'hB0B0_0000_0000_0001);
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (m_tvalid !== 1'b0 || s_tready !== 2'b00) begin errors++; $display("FAIL gate_hold c=%0d got tvalid=%b s_tready=%b exp=0/00", c, m_tvalid, s_tready); end
      tick();
    end
`ifdef PCIE_TX_ARB_STATS_EN
    checks++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL gate_stall_cnt got=%0d exp=10", stall_cnt); end
`endif
    tx_buf_av = 6'd2;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL gate_same_cycle got=%b exp=0", m_tvalid); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || grant !== 2'd1 || m_tlast !== 1'b1) begin
      errors++; $display("FAIL gate_start got tvalid=%b grant=%0d tlast=%b exp=1/1/1", m_tvalid, grant, m_tlast);
    end
    checks++; if (m_tdata !== 64'hB0B0_0000_0000_0001) begin errors++; $display("FAIL gate_data got=%h exp=b0b0000000000001", m_tdata); end
    tick();
    set_req(1, 1'b0, 1'b0, 64'd0);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_single_beat_done got busy=%b exp=0", busy); end
  endtask

  task automatic test_backpressure;
    bit pv [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit pr [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int beat;
    do_reset();
    tx_buf_av = 6'd8;
    m_tready  = 1'b1;
    beat = 0;
    set_req(0, 1'b1, 1'b0, {8'hA0, 48'd0, 8'd0});
    tick();
    for (int c = 0; c < 7; c++) begin
      tx_buf_av = 6'd0;
      set_req(1, 1'b1, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
      set_req(0, pv[c], beat == 3, {8'hA0, 48'd0, 8'(beat)});
      m_tready = pr[c];
      #1;
      checks++; if (m_tvalid !== pv[c]) begin errors++; $display("FAIL bp_tvalid c=%0d got=%b exp=%b", c, m_tvalid, pv[c]); end
      checks++; if (m_tdata !== {8'hA0, 48'd0, 8'(beat)}) begin errors++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, m_tdata, {8'hA0, 48'd0, 8'(beat)}); end
      checks++; if (s_tready !== {1'b0, pr[c]}) begin errors++; $display("FAIL bp_s_tready c=%0d got=%b exp=%b", c, s_tready, {1'b0, pr[c]}); end
      checks++; if (grant !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL bp_grant c=%0d got grant=%0d busy=%b exp=0/1", c, grant, busy); end
      tick();
      if (pv[c] && pr[c]) beat++;
    end
    set_req(0, 1'b0, 1'b0, 64'd0);
    m_tready = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_end got busy=%b tvalid=%b exp=0/0", busy, m_tvalid); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_low_buf_no_grant got busy=%b exp=0", busy); end
    tx_buf_av = 6'd8;
    set_req(1, 1'b1, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
    tick();
    checks++; if (grant !== 2'd1 || m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_next_grant got grant=%0d tvalid=%b exp=1/1", grant, m_tvalid); end
    tick();
    set_req(1, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic test_reset_midpacket;
    do_reset();
    tx_buf_av = 6'd8;
    m_tready  = 1'b1;
    set_req(0, 1'b1, 1'b1, 64'h0000_0000_0000_00C0);
    tick();
    tick();
    set_req(0, 1'b0, 1'b0, 64'd0);
    set_req(1, 1'b1, 1'b0, 64'h0000_0000_0000_00D0);
    tick();
    checks++; if (grant !== 2'd1) begin errors++; $display("FAIL rst_pre_grant got=%0d exp=1", grant); end
    tick();
    set_req(1, 1'b1, 1'b0, 64'h0000_0000_0000_00D1);
    #1;
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h0000_0000_0000_00D1) begin errors++; $display("FAIL rst_beat2 got=%b/%h exp=1/00000000000000d1", m_tvalid, m_tdata); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_async got tvalid=%b s_tready=%b busy=%b exp=0/00/0", m_tvalid, s_tready, busy);
    end
    checks++; if (m_tdata !== 64'd0 || grant !== 2'd0) begin errors++; $display("FAIL rst_async_data got=%h grant=%0d exp=0/0", m_tdata, grant); end
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b1, 64'h0000_0000_0000_00C1);
    tick();
    checks++; if (grant !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL rst_restart got grant=%0d busy=%b exp=0/1", grant, busy); end
    checks++; if (m_tdata !== 64'h0000_0000_0000_00C1) begin errors++; $display("FAIL rst_restart_data got=%h exp=00000000000000c1", m_tdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_wrap3;
    int exp_g;
    do_reset();
    tx_buf_av = 6'd8;
    mr3 = 1'b1;
    set_req3(1, 1'b1, 1'b1, 64'h0000_0000_0000_0011);
    tick();
    tick();
    for (int i = 0; i < 3; i++) set_req3(i, 1'b1, 1'b1, {8'(i + 1), 56'd0});
    for (int k = 0; k < 3; k++) begin
      exp_g = (2 + k) % 3;
      #1;
      checks++; if (mv3 !== 1'b0) begin errors++; $display("FAIL wrap_idle k=%0d got=%b exp=0", k, mv3); end
      tick();
      checks++; if (g3 !== 2'(exp_g) || mv3 !== 1'b1) begin errors++; $display("FAIL wrap_grant k=%0d got=%0d/%b exp=%0d/1", k, g3, mv3, exp_g); end
      checks++; if (md3 !== {8'(exp_g + 1), 56'd0}) begin errors++; $display("FAIL wrap_data k=%0d got=%h exp=%h", k, md3, {8'(exp_g + 1), 56'd0}); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_buf_gating();
    test_backpressure();
    test_reset_midpacket();
    test_wrap3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arbiter.md
Name: pcie_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the PCIe core's 64-bit AXI4-Stream TX interface (s_axis_tx_*) between N_REQ TLP sources, e.g. the Ethernet-to-PCIe TLP path and the local completion generator.
- Starts a new TLP only when the core reports enough TX buffer space.
- Holds the grant until tlast, so TLPs never interleave.
- Sits in pcie_top, between the TLP sources and pcie_7x_support.

Parameters:
- N_REQ, 2: number of requesters; legal range 2..4.
- DATA_WIDTH, 64: tdata width; tkeep width is DATA_WIDTH/8.
- USER_WIDTH, 4: tuser width per requester (discontinue, str, err_fwd, ecrc_gen).
- MIN_BUF_AV, 2: minimum tx_buf_av required before a new grant is issued.

Ports:
- pcie_clk  in  1  PCIe user clock; the only clock.
- pcie_rst_n  in  1  reset, asynchronous, active-low.
- tx_buf_av  in  6  free TX buffers reported by the PCIe core.
- s_axis_tvalid  in  N_REQ  per-requester valid.
- s_axis_tready  out  N_REQ  per-requester ready.
- s_axis_tdata  in  N_REQ*DATA_WIDTH  requester i data is in slice i.
- s_axis_tkeep  in  N_REQ*DATA_WIDTH/8  per-requester keep.
- s_axis_tlast  in  N_REQ  per-requester last.
- s_axis_tuser  in  N_REQ*USER_WIDTH  per-requester user.
- m_axis_tvalid  out  1  valid to the core.
- m_axis_tready  in  1  ready from the core.
- m_axis_tdata  out  DATA_WIDTH  data to the core.
- m_axis_tkeep  out  DATA_WIDTH/8  keep to the core.
- m_axis_tlast  out  1  last to the core.
- m_axis_tuser  out  USER_WIDTH  user to the core.
- grant_idx  out  2  index of the current or last granted requester.
- busy  out  1  high while a packet is in flight.

Behaviour:
- Reset (pcie_rst_n low, asynchronous):
  - state = IDLE, rr_ptr = 0, grant_idx = 0, busy = 0.
  - All m_axis_* = 0; all s_axis_tready = 0.
  - Deassertion is sampled synchronously on pcie_clk.
- State IDLE:
  - Outputs: m_axis_tvalid = 0, s_axis_tready = 0.
  - Eligible requester: s_axis_tvalid[i] = 1 and tx_buf_av >= MIN_BUF_AV (unsigned 6-bit compare).
  - Winner: first eligible index searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - If a winner exists: register grant_idx = winner, go to XFER next cycle, set busy = 1.
  - No eligible requester: stay in IDLE.
- State XFER:
  - Data path is combinational mux on the granted slice: m_axis_tvalid/tdata/tkeep/tlast/tuser = s_axis_*[grant_idx].
  - s_axis_tready[grant_idx] = m_axis_tready; all other s_axis_tready = 0.
  - A beat transfers when m_axis_tvalid and m_axis_tready are both high.
  - On a transfer with tlast = 1: go to IDLE, rr_ptr = (grant_idx+1) mod N_REQ, busy = 0.
  - tx_buf_av is ignored once a packet has started.
- Latency:
  - One cycle from IDLE arbitration to the first beat on m_axis.
  - One bubble cycle (IDLE) between back-to-back packets.
  - Sustained throughput within a packet is 1 beat/cycle.
- Boundary conditions:
  - Granted requester drops tvalid mid-packet: grant is held and m_axis_tvalid follows it low; no re-arbitration.
  - Single-beat packet (tlast on the first beat): legal; returns to IDLE after one beat.
  - Requester not granted: its tvalid is ignored.
  - tx_buf_av falls below MIN_BUF_AV mid-packet: no effect.
  - All N_REQ requesting continuously: grants rotate 0,1,..,N_REQ-1,0; no starvation.
  - rr_ptr wraps at N_REQ-1 -> 0, including for N_REQ=3.
  - Reset mid-packet: the packet is abandoned, outputs drop to 0 immediately, and arbitration restarts at requester 0.

Optional Feature:
- Macro: PCIE_TX_ARB_STATS_EN.
- When defined, add these ports:
  - stats_clr  in  1
  - stats_pkt_cnt  out  N_REQ*32
  - stats_stall_cnt  out  32
- stats_pkt_cnt[i] increments on every accepted tlast beat from requester i.
- stats_stall_cnt increments on every IDLE cycle where some tvalid is high but tx_buf_av < MIN_BUF_AV.
- Counters wrap at 2^32 - 1 -> 0.
- stats_clr (synchronous) zeroes all counters and takes priority over a same-cycle increment.
- Counters reset to 0.
- When not defined: the ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Single requester: req0 sends a 3-beat TLP, tdata 0x11..,0x22..,0x33.., tx_buf_av=8, m_tready=1 -> m_axis carries the 3 beats in order starting 1 cycle after tvalid; grant_idx=0; tlast on beat 3; busy returns to 0.
- Fairness: req0 and req1 stream 2-beat packets continuously -> grant sequence 0,1,0,1; exactly one bubble between packets; no beat interleaving.
- Buffer gating: tx_buf_av=1 with req1 valid -> no m_tvalid for 10 cycles (stall count 10 with PCIE_TX_ARB_STATS_EN); raise to 2 -> packet starts next cycle.
- Backpressure: m_tready toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated; s_tready[granted] mirrors m_tready; other s_tready stay 0.
- Wrap/N_REQ=3: all three requesters valid with rr_ptr=2 -> grants 2,0,1.
- Reset: assert pcie_rst_n=0 during beat 2 of 4 -> m_tvalid=0 the same cycle; after release, the next grant goes to requester 0.
